// File: rtl/hub75_scan_scheduler.sv
// hub75_scan_scheduler: drives a HUB75 LED panel with binary-coded-modulation
// scan order. For each (row, bit plane) it fetches WIDTH columns of pixel bits
// from a framebuffer reader, shifts them out, blanks, latches and displays the
// plane for BCM_BASE<<bit cycles, then advances bit first and row second.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   enable              run request, sampled in IDLE and at the end of DISPLAY
//   fetch_req/x/row/bit framebuffer request (registered)
//   fetch_ack/data      framebuffer response, {B2,B1,G2,G1,R2,R1}
//   panel_clk/lat/oe    panel shift clock, latch, blank (oe=1 blanks)
//   addr, col           panel row address and colour pins
//   frame_done          one-cycle pulse when row wraps to 0
module hub75_scan_scheduler #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned ROWS      = 32,
    parameter int unsigned BIT_DEPTH = 8,
    parameter int unsigned BCM_BASE  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       fetch_req,
    output logic [5:0] fetch_x,
    output logic [4:0] fetch_row,
    output logic [2:0] fetch_bit,
    input  logic       fetch_ack,
    input  logic [5:0] fetch_data,
    output logic       panel_clk,
    output logic       panel_lat,
    output logic       panel_oe,
    output logic [4:0] addr,
    output logic [5:0] col,
    output logic       frame_done
);

    localparam int unsigned COL_W  = 6;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned DATA_W = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_idx_q, col_idx_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frame_wrap;

    logic               fetch_req_q, fetch_req_d;
    logic [COL_W-1:0]   fetch_x_q, fetch_x_d;
    logic [ROW_W-1:0]   fetch_row_q, fetch_row_d;
    logic [BIT_W-1:0]   fetch_bit_q, fetch_bit_d;
    logic               panel_clk_q, panel_clk_d;
    logic               panel_lat_q, panel_lat_d;
    logic               panel_oe_q, panel_oe_d;
    logic [ROW_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]  col_pins_q, col_pins_d;
    logic               frame_done_q, frame_done_d;

    // Response accepted only while a request is actually outstanding
    logic fetch_hit;
    assign fetch_hit = (state_q == S_FETCH) && fetch_req_q && fetch_ack;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and scan counters
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        row_d      = row_q;
        bit_d      = bit_q;
        cnt_d      = cnt_q;
        frame_wrap = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d   = S_FETCH;
                    col_idx_d = '0;
                end
            end
            S_FETCH: begin
                if (fetch_hit) begin
                    state_d = S_SHIFT_LO;
                end
            end
            S_SHIFT_LO: state_d = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (col_idx_q < COL_W'(WIDTH - 1)) begin
                    col_idx_d = col_idx_q + COL_W'(1);
                    state_d   = S_FETCH;
                end else begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: state_d = S_LATCH;
            S_LATCH: begin
                // Load display length minus one; DISPLAY ends when it hits zero
                cnt_d   = (CNT_W'(BCM_BASE) << bit_q) - CNT_W'(1);
                state_d = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (cnt_q == '0) begin
                    if (bit_q == BIT_W'(BIT_DEPTH - 1)) begin
                        bit_d = '0;
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            row_d      = '0;
                            frame_wrap = 1'b1;
                        end else begin
                            row_d = row_q + ROW_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                    col_idx_d = '0;
                    state_d   = enable ? S_FETCH : S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs registered from the upcoming state so they align with state_q
    always_comb begin
        fetch_req_d  = (state_d == S_FETCH);
        fetch_x_d    = col_idx_d;
        fetch_row_d  = row_d;
        fetch_bit_d  = bit_d;
        panel_clk_d  = (state_d == S_SHIFT_HI);
        panel_lat_d  = (state_d == S_LATCH);
        panel_oe_d   = (state_d != S_DISPLAY);
        addr_d       = (state_d == S_BLANK) ? row_d : addr_q;
        col_pins_d   = fetch_hit ? fetch_data : col_pins_q;
        frame_done_d = frame_wrap;
    end

    // Datapath and output registers; reset blanks the panel immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_idx_q    <= '0;
            row_q        <= '0;
            bit_q        <= '0;
            cnt_q        <= '0;
            fetch_req_q  <= 1'b0;
            fetch_x_q    <= '0;
            fetch_row_q  <= '0;
            fetch_bit_q  <= '0;
            panel_clk_q  <= 1'b0;
            panel_lat_q  <= 1'b0;
            panel_oe_q   <= 1'b1;
            addr_q       <= '0;
            col_pins_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_idx_q    <= col_idx_d;
            row_q        <= row_d;
            bit_q        <= bit_d;
            cnt_q        <= cnt_d;
            fetch_req_q  <= fetch_req_d;
            fetch_x_q    <= fetch_x_d;
            fetch_row_q  <= fetch_row_d;
            fetch_bit_q  <= fetch_bit_d;
            panel_clk_q  <= panel_clk_d;
            panel_lat_q  <= panel_lat_d;
            panel_oe_q   <= panel_oe_d;
            addr_q       <= addr_d;
            col_pins_q   <= col_pins_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fetch_req  = fetch_req_q;
    assign fetch_x    = fetch_x_q;
    assign fetch_row  = fetch_row_q;
    assign fetch_bit  = fetch_bit_q;
    assign panel_clk  = panel_clk_q;
    assign panel_lat  = panel_lat_q;
    assign panel_oe   = panel_oe_q;
    assign addr       = addr_q;
    assign col        = col_pins_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Directed bench for hub75_scan_scheduler with WIDTH=4, ROWS=2, BIT_DEPTH=2,
// BCM_BASE=2: per-cycle vector table for the first plane, then scan-order,
// enable-drop, fetch wait-state and asynchronous reset sequences.
module tb_hub75_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       fetch_req;
    logic [5:0] fetch_x;
    logic [4:0] fetch_row;
    logic [2:0] fetch_bit;
    logic       fetch_ack;
    logic [5:0] fetch_data;
    logic       panel_clk, panel_lat, panel_oe;
    logic [4:0] addr;
    logic [5:0] col;
    logic       frame_done;

    int n_cmp  = 0;
    int n_fail = 0;

    hub75_scan_scheduler #(
        .WIDTH(4), .ROWS(2), .BIT_DEPTH(2), .BCM_BASE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_row(fetch_row),
        .fetch_bit(fetch_bit), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe(panel_oe),
        .addr(addr), .col(col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Panel safety invariants, checked every cycle
    logic [4:0] prev_addr = 5'd0;
    always @(negedge clk) begin
        if (panel_lat) check("inv_lat_blanked", 32'(panel_oe), 32'd1);
        if (!panel_oe) check("inv_oe_only_display", 32'({panel_lat, panel_clk, fetch_req}), 32'd0);
        if (addr != prev_addr) check("inv_addr_blanked", 32'(panel_oe), 32'd1);
        prev_addr = addr;
    end

    typedef struct {
        logic [5:0] d;
        logic       req;
        logic [5:0] x;
        logic [4:0] row;
        logic [2:0] bp;
        logic       pclk;
        logic       lat;
        logic       oe;
        logic [4:0] ad;
        logic [5:0] c;
    } vec_t;

    function automatic vec_t mkv(input logic [5:0] d, input logic rq, input logic [5:0] x,
                                 input logic [4:0] r, input logic [2:0] b, input logic pc,
                                 input logic la, input logic oe, input logic [4:0] ad,
                                 input logic [5:0] c);
        vec_t v;
        v.d = d; v.req = rq; v.x = x; v.row = r; v.bp = b;
        v.pclk = pc; v.lat = la; v.oe = oe; v.ad = ad; v.c = c;
        return v;
    endfunction

    vec_t vecs[17];

    initial begin
        logic [5:0] J, A, B, C, D;
        int next_start, cur_row, cur_bit, prev_bit;
        int rises, lats, oe_low;
        logic prev_pclk;
        bit found;

        J = 6'b111111; A = 6'b101010; B = 6'b010101; C = 6'b111000; D = 6'b000111;
        //                d  rq x     row   bit   pc    la    oe    ad    col
        vecs[0]  = mkv(J, 1, 6'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, 6'd0);
        vecs[1]  = mkv(A, 0, 6'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, A);
        vecs[2]  = mkv(J, 0, 6'd0, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd0, A);
        vecs[3]  = mkv(J, 1, 6'd1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, A);
        vecs[4]  = mkv(B, 0, 6'd1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, B);
        vecs[5]  = mkv(J, 0, 6'd1, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd0, B);
        vecs[6]  = mkv(J, 1, 6'd2, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, B);
        vecs[7]  = mkv(C, 0, 6'd2, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, C);
        vecs[8]  = mkv(J, 0, 6'd2, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd0, C);
        vecs[9]  = mkv(J, 1, 6'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, C);
        vecs[10] = mkv(D, 0, 6'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, D);
        vecs[11] = mkv(J, 0, 6'd3, 5'd0, 3'd0, 1'b1, 1'b0, 1'b1, 5'd0, D);
        vecs[12] = mkv(J, 0, 6'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 5'd0, D);
        vecs[13] = mkv(J, 0, 6'd3, 5'd0, 3'd0, 1'b0, 1'b1, 1'b1, 5'd0, D);
        vecs[14] = mkv(J, 0, 6'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, D);
        vecs[15] = mkv(J, 0, 6'd3, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 5'd0, D);
        vecs[16] = mkv(J, 1, 6'd0, 5'd0, 3'd1, 1'b0, 1'b0, 1'b1, 5'd0, D);

        // Reset values
        rst_n = 1'b0; enable = 1'b0; fetch_ack = 1'b0; fetch_data = 6'd0;
        @(negedge clk);
        check("rst_oe", 32'(panel_oe), 32'd1);
        check("rst_outs", 32'({panel_clk, panel_lat, fetch_req, frame_done}), 32'd0);
        check("rst_addr_col", 32'({addr, col}), 32'd0);
        @(negedge clk);
        enable = 1'b1; fetch_ack = 1'b1;
        rst_n = 1'b1;

        // First plane, cycle by cycle
        for (int i = 0; i < 17; i++) begin
            fetch_data = vecs[i].d;
            @(negedge clk);
            check($sformatf("v%0d_req", i),  32'(fetch_req), 32'(vecs[i].req));
            check($sformatf("v%0d_x", i),    32'(fetch_x),   32'(vecs[i].x));
            check($sformatf("v%0d_row", i),  32'(fetch_row), 32'(vecs[i].row));
            check($sformatf("v%0d_bit", i),  32'(fetch_bit), 32'(vecs[i].bp));
            check($sformatf("v%0d_pclk", i), 32'(panel_clk), 32'(vecs[i].pclk));
            check($sformatf("v%0d_lat", i),  32'(panel_lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_oe", i),   32'(panel_oe),  32'(vecs[i].oe));
            check($sformatf("v%0d_addr", i), 32'(addr),      32'(vecs[i].ad));
            check($sformatf("v%0d_col", i),  32'(col),       32'(vecs[i].c));
            check($sformatf("v%0d_fd", i),   32'(frame_done), 32'd0);
        end

        // Free run: plane order, plane lengths, per-plane edge counts, frame period
        next_start = 35; cur_row = 0; cur_bit = 1;
        rises = 0; lats = 0; oe_low = 0; prev_pclk = 1'b0;
        for (int k = 18; k <= 173; k++) begin
            fetch_data = 6'($urandom);
            @(negedge clk);
            check($sformatf("k%0d_fd", k), 32'(frame_done), 32'(((k - 1) % 68) == 0));
            check($sformatf("k%0d_pstart", k), 32'(fetch_req && fetch_x == 6'd0), 32'(k == next_start));
            if (k == next_start) begin
                check($sformatf("k%0d_clk_edges", k), 32'(rises), 32'd4);
                check($sformatf("k%0d_lat_pulses", k), 32'(lats), 32'd1);
                check($sformatf("k%0d_oe_cycles", k), 32'(oe_low), 32'(2 << cur_bit));
                prev_bit = cur_bit;
                if (cur_bit == 1) begin
                    cur_bit = 0;
                    cur_row = cur_row ^ 1;
                end else begin
                    cur_bit = 1;
                end
                check($sformatf("k%0d_prow", k), 32'(fetch_row), 32'(cur_row));
                check($sformatf("k%0d_pbit", k), 32'(fetch_bit), 32'(cur_bit));
                next_start = next_start + ((cur_bit == 0) ? 16 : 18);
                rises = 0; lats = 0; oe_low = 0;
            end
            if (panel_clk && !prev_pclk) rises++;
            if (panel_lat) lats++;
            if (!panel_oe) oe_low++;
            prev_pclk = panel_clk;
        end

        // Drop enable mid-shift at row=1, bit=0: plane completes, then idle
        enable = 1'b0;
        for (int k = 174; k <= 192; k++) begin
            @(negedge clk);
            check($sformatf("dis%0d_oe", k), 32'(panel_oe), 32'(!(k == 185 || k == 186)));
            check($sformatf("dis%0d_lat", k), 32'(panel_lat), 32'(k == 184));
            check($sformatf("dis%0d_addr", k), 32'(addr), 32'(k >= 183));
            if (k >= 187) check($sformatf("dis%0d_idle_req", k), 32'(fetch_req), 32'd0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("resume_req", 32'(fetch_req), 32'd1);
        check("resume_pos", 32'({fetch_x, fetch_row, fetch_bit}), 32'({6'd0, 5'd1, 3'd1}));

        // Fetch wait states at col=2
        fetch_data = 6'b001100;
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (fetch_req && fetch_x == 6'd2) found = 1'b1;
        end
        check("wait_reach_col2", 32'(found), 32'd1);
        fetch_ack = 1'b0; fetch_data = 6'b111111;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            check($sformatf("wait%0d_req", n), 32'(fetch_req), 32'd1);
            check($sformatf("wait%0d_pclk", n), 32'(panel_clk), 32'd0);
            check($sformatf("wait%0d_col", n), 32'(col), 32'b001100);
            check($sformatf("wait%0d_x", n), 32'(fetch_x), 32'd2);
        end
        fetch_ack = 1'b1; fetch_data = 6'b110011;
        @(negedge clk);
        check("ack_lo_req", 32'(fetch_req), 32'd0);
        check("ack_lo_col", 32'(col), 32'b110011);
        check("ack_lo_pclk", 32'(panel_clk), 32'd0);
        @(negedge clk);
        check("ack_hi_pclk", 32'(panel_clk), 32'd1);

        // Asynchronous reset in the middle of DISPLAY
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (!panel_oe) found = 1'b1;
        end
        check("reach_display", 32'(found), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_oe", 32'(panel_oe), 32'd1);
        check("arst_outs", 32'({panel_clk, panel_lat, fetch_req, frame_done}), 32'd0);
        check("arst_addr_col", 32'({addr, col}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", 32'(fetch_req), 32'd1);
        check("post_rst_pos", 32'({fetch_x, fetch_row, fetch_bit}), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
